pe_vec_mac: RTL and testbench

PE_VEC_MAC -- requirements
Module: pe_vec_mac

---
 rtl/pe_vec_mac.sv | 146 ++++++++++++++
 tb/tb_pe_vec_mac.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pe_vec_mac.sv
// Vector dot-product PE: streams A operands against a local B-operand RAM
// through a 3-stage signed multiply-accumulate pipeline with a result handshake.
module pe_vec_mac #(
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 40,
  parameter int L_RAM_SIZE = 6,
  parameter int BYTE_SWAP  = 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  we,
  input  logic [L_RAM_SIZE-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  start,
  input  logic [L_RAM_SIZE:0]   len,
  input  logic                  acc_clear,
  input  logic                  s_ain_valid,
  output logic                  s_ain_ready,
  input  logic [DATA_W-1:0]     s_ain_data,
  output logic                  busy,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ACC_W-1:0]      m_data
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t                  r_state;
  logic [L_RAM_SIZE:0]     r_len;
  logic [L_RAM_SIZE:0]     r_cnt;
  logic [1:0]              r_drain;
  logic                    r_ready;
  logic                    r_busy;
  logic                    r_m_valid;

  logic [DATA_W-1:0]       r_mem [2**L_RAM_SIZE];
  logic                    r_s1_vld;
  logic [DATA_W-1:0]       r_a;
  logic [DATA_W-1:0]       r_b;
  logic                    r_s2_vld;
  logic signed [2*DATA_W-1:0] r_prod;
  logic [ACC_W-1:0]        r_acc;

  logic                    w_beat;
  logic                    w_clear;
  logic [L_RAM_SIZE:0]     w_cnt_nxt;
  logic signed [DATA_W-1:0] w_a;
  logic signed [DATA_W-1:0] w_b;
  logic signed [ACC_W-1:0] w_prod_ext;

  function automatic logic [DATA_W-1:0] f_swap(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] y;
    y = '0;
    for (int i = 0; i < DATA_W / 8; i++) y[8*i +: 8] = x[DATA_W-8-8*i +: 8];
    return y;
  endfunction

  assign w_beat    = s_ain_valid & r_ready;
  assign w_clear   = start & acc_clear & (r_state == ST_IDLE);
  assign w_cnt_nxt = r_cnt + (L_RAM_SIZE+1)'(1);

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= ST_IDLE;
      r_len     <= '0;
      r_cnt     <= '0;
      r_drain   <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_m_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_len  <= len;
          r_cnt  <= '0;
          r_busy <= 1'b1;
          if (len != '0) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end else begin
            r_state   <= ST_DONE;
            r_m_valid <= 1'b1;
          end
        end
        ST_RUN: if (w_beat) begin
          r_cnt <= w_cnt_nxt;
          if (w_cnt_nxt == r_len) begin
            r_ready <= 1'b0;
            r_drain <= '0;
            r_state <= ST_DRAIN;
          end
        end
        // Three cycles cover S1->S2->S3 for the final beat.
        ST_DRAIN: if (r_drain == 2'd2) begin
          r_state   <= ST_DONE;
          r_m_valid <= 1'b1;
        end else begin
          r_drain <= r_drain + 2'd1;
        end
        ST_DONE: if (m_ready) begin
          r_state   <= ST_IDLE;
          r_m_valid <= 1'b0;
          r_busy    <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the operand RAM has no reset; its contents are don't-care until written.
  always_ff @(posedge aclk) begin
    if (we && r_state == ST_IDLE) r_mem[waddr] <= wdata;
  end

  always_ff @(posedge aclk) begin
    if (w_beat) begin
      r_a <= s_ain_data;
      r_b <= r_mem[r_cnt[L_RAM_SIZE-1:0]];
    end
    if (r_s1_vld) r_prod <= w_a * w_b;
  end

  assign w_a        = (BYTE_SWAP != 0) ? f_swap(r_a) : r_a;
  assign w_b        = (BYTE_SWAP != 0) ? f_swap(r_b) : r_b;
  assign w_prod_ext = ACC_W'(r_prod);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_acc    <= '0;
    end else begin
      r_s1_vld <= w_beat;
      r_s2_vld <= r_s1_vld;
      if (w_clear)       r_acc <= '0;
      else if (r_s2_vld) r_acc <= r_acc + w_prod_ext;
    end
  end

  assign s_ain_ready = r_ready;
  assign busy        = r_busy;
  assign m_valid     = r_m_valid;
  assign m_data      = r_acc;

endmodule

// File: tb/tb_pe_vec_mac.sv
// Directed bench for pe_vec_mac: one plain and one byte-swapping instance driven
// in lockstep, checked against hand-computed dot products.
module tb_pe_vec_mac;

  localparam int DW = 16;
  localparam int AW = 40;
  localparam int LR = 6;

  logic          clk = 1'b0;
  logic          aresetn = 1'b1;
  logic          we = 1'b0;
  logic [LR-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          start = 1'b0;
  logic [LR:0]   len = '0;
  logic          acc_clear = 1'b0;
  logic          s_ain_valid = 1'b0;
  logic [DW-1:0] s_ain_data = '0;
  logic          m_ready = 1'b0;

  logic          s_ain_ready0, s_ain_ready1, busy0, busy1, m_valid0, m_valid1;
  logic [AW-1:0] m_data0, m_data1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int beat_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pe_vec_mac #(.DATA_W(DW), .ACC_W(AW), .L_RAM_SIZE(LR), .BYTE_SWAP(0)) dut0 (
    .aclk(clk), .aresetn(aresetn), .we(we), .waddr(waddr), .wdata(wdata),
    .start(start), .len(len), .acc_clear(acc_clear),
    .s_ain_valid(s_ain_valid), .s_ain_ready(s_ain_ready0), .s_ain_data(s_ain_data),
    .busy(busy0), .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0)
  );

  pe_vec_mac #(.DATA_W(DW), .ACC_W(AW), .L_RAM_SIZE(LR), .BYTE_SWAP(1)) dut1 (
    .aclk(clk), .aresetn(aresetn), .we(we), .waddr(waddr), .wdata(wdata),
    .start(start), .len(len), .acc_clear(acc_clear),
    .s_ain_valid(s_ain_valid), .s_ain_ready(s_ain_ready1), .s_ain_data(s_ain_data),
    .busy(busy1), .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic write_ram(input logic [LR-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic start_op(input logic [LR:0] l, input logic c);
    start = 1'b1; len = l; acc_clear = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents n beats; records the cycle of the last accepted beat.
  task automatic feed(input logic [DW-1:0] a [4], input int n, input bit gaps);
    int t;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        s_ain_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      s_ain_valid = 1'b1;
      s_ain_data  = a[i];
      t = 0;
      while (!s_ain_ready0 && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!s_ain_ready0) check("ready_timeout", 0, 1);
      beat_cyc = cyc;
      @(negedge clk);
    end
    s_ain_valid = 1'b0;
  endtask

  task automatic wait_done(input longint exp0, input longint exp1, input bit hold, input bit chk_lat);
    int t;
    t = 0;
    while (!m_valid0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("m_valid", longint'(m_valid0), 1);
    if (chk_lat) check("latency", longint'(cyc - beat_cyc), 4);
    check("m_data0", longint'($signed(m_data0)), exp0);
    check("m_data1", longint'($signed(m_data1)), exp1);
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        start = 1'b1; len = 7'd1; acc_clear = 1'b1;
        @(negedge clk);
        check("hold_valid", longint'(m_valid0), 1);
        check("hold_data", longint'($signed(m_data0)), exp0);
      end
      start = 1'b0;
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("busy_after_done", longint'(busy0), 0);
  endtask

  logic [DW-1:0] va [4];
  logic          seen;

  initial begin
    #2 aresetn = 1'b0;
    #3;
    check("rst_busy", longint'(busy0), 0);
    check("rst_ready", longint'(s_ain_ready0), 0);
    check("rst_mvalid", longint'(m_valid0), 0);
    check("rst_mdata", longint'(m_data0), 0);
    repeat (2) @(negedge clk);
    aresetn = 1'b1;

    for (int i = 0; i < 4; i++) write_ram(LR'(i), DW'(i + 1));

    // Back-to-back 4-beat dot product, cleared accumulator.
    va = '{16'd5, 16'd6, 16'd7, 16'd8};
    start_op(7'd4, 1'b1);
    check("busy_run", longint'(busy0), 1);
    feed(va, 4, 1'b0);
    check("ready_drop", longint'(s_ain_ready0), 0);
    wait_done(70, 70 * 65536, 1'b0, 1'b1);

    // Same again, accumulating onto the previous result.
    start_op(7'd4, 1'b0);
    feed(va, 4, 1'b0);
    wait_done(140, 140 * 65536, 1'b0, 1'b1);

    // Zero-length op goes straight to DONE with the held accumulator.
    start_op(7'd0, 1'b0);
    check("len0_immediate", longint'(m_valid0), 1);
    wait_done(140, 140 * 65536, 1'b0, 1'b0);

    // Signed operands, back-to-back then with valid gaps.
    write_ram(6'd0, 16'hFFFD);
    va = '{16'h7FFF, 16'h0, 16'h0, 16'h0};
    start_op(7'd1, 1'b1);
    feed(va, 1, 1'b0);
    wait_done(-98301, 66177, 1'b0, 1'b1);
    start_op(7'd1, 1'b1);
    feed(va, 1, 1'b1);
    wait_done(-98301, 66177, 1'b0, 1'b1);

    write_ram(6'd0, 16'd1);
    va = '{16'd5, 16'd6, 16'd7, 16'd8};
    start_op(7'd4, 1'b1);
    feed(va, 4, 1'b1);
    wait_done(70, 70 * 65536, 1'b0, 1'b1);

    // Byte swap, write during RUN dropped, DONE held with starts ignored.
    write_ram(6'd0, 16'h0200);
    va = '{16'h0300, 16'h0, 16'h0, 16'h0};
    start_op(7'd1, 1'b1);
    write_ram(6'd0, 16'h0500);
    feed(va, 1, 1'b0);
    wait_done(393216, 6, 1'b1, 1'b1);
    check("start_ignored_acc", longint'($signed(m_data0)), 393216);

    // Reset pulse mid-RUN aborts the op.
    va = '{16'd5, 16'd6, 16'd7, 16'd8};
    start_op(7'd4, 1'b1);
    feed(va, 2, 1'b0);
    aresetn = 1'b0;
    #1;
    check("abort_busy", longint'(busy0), 0);
    check("abort_ready", longint'(s_ain_ready0), 0);
    check("abort_mvalid", longint'(m_valid0), 0);
    check("abort_mdata0", longint'(m_data0), 0);
    check("abort_mdata1", longint'(m_data1), 0);
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (m_valid0 || busy0) seen = 1'b1;
    end
    check("no_mvalid_after_abort", longint'(seen), 0);

    // Start presented as reset releases is honoured on the first edge.
    aresetn = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    start_op(7'd0, 1'b0);
    check("first_start_valid", longint'(m_valid0), 1);
    wait_done(0, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
